vga_sync_decoder: RTL and testbench

- Receive end of the VGA timing interface: samples the hsync/vsync pulse stream from the timing generator (800x600 visible, 50 MHz pixel clock, active-low sync pulses).
- Recovers the pixel x/y position and measures line period, sync width and lines per frame.
- Declares lock once timing is stable.
- Used as an on-chip timing checker and as the position source for the overlay/colour logic.

---
 rtl/vga_timing_pkg.sv | 19 +
 rtl/sync_edge_det.sv | 45 ++++
 rtl/vga_sync_decoder.sv | 191 +++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Timing constants for the 800x600 @ 50 MHz VGA mode. The same numbers are
// used by the timing generator. Also holds the lock-state encoding for the
// receive-side sync decoder.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int H_TOTAL = 1040;  // pixel clocks per line
  localparam int H_SYNC  = 120;   // hsync low width in pixel clocks
  localparam int V_TOTAL = 666;   // lines per frame

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Brings one asynchronous sync input into the clock domain through two flops.
// A third history flop is used to detect edges on the synchronised level.
//
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset (all flops go to 1, idle high)
//   i_async  asynchronous input
//   o_level  synchronised level
//   o_fall   one-cycle pulse on a synchronised 1->0 transition
//   o_rise   one-cycle pulse on a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_fall,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  // Resetting to 1 matches the idle level of the active-low sync pulses,
  // so releasing reset never creates a false falling edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_hist <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_hist & ~r_sync;
  assign o_rise  = ~r_hist & r_sync;

endmodule

// File: rtl/vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// vga_sync_decoder
// Receive side of the VGA timing interface. Recovers pixel x/y position from
// the hsync/vsync stream, measures line period, hsync width and lines per
// frame, and declares lock after LOCK_LINES consecutive in-tolerance lines.
//
// Ports:
//   clk50      pixel clock (50 MHz)
//   reset      asynchronous active-high reset
//   hsync_in   horizontal sync, active low, asynchronous
//   vsync_in   vertical sync, active low, asynchronous
//   locked     timing stable and within tolerance
//   x_pos      clocks since last hsync fall (saturates at 2047)
//   y_pos      lines since last vsync fall (saturates at 2047)
//   h_period   last measured line period in clocks
//   h_width    last measured hsync low width in clocks
//   v_lines    last measured lines per frame
//   new_frame  one-cycle pulse after a vsync fall
//   line_err   one-cycle pulse when a completed line is out of tolerance
// ---------------------------------------------------------------------------
module vga_sync_decoder #(
  parameter int H_TOTAL    = vga_timing_pkg::H_TOTAL,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int TOL        = 2,
  parameter int LOCK_LINES = 4
) (
  input  logic        clk50,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic        locked,
  output logic [10:0] x_pos,
  output logic [10:0] y_pos,
  output logic [11:0] h_period,
  output logic [11:0] h_width,
  output logic [10:0] v_lines,
  output logic        new_frame,
  output logic        line_err
);

  import vga_timing_pkg::*;

  logic        w_hLevel, w_hFall, w_hRise;
  logic        w_vLevel, w_vFall, w_vRise;
  logic        w_unusedVsync;
  logic [11:0] r_hcnt, r_wcnt, r_hPeriod, r_hWidth;
  logic [10:0] r_ycnt, r_vLines;
  logic        r_widthDone, r_newFrame, r_lineErr;
  logic [12:0] w_period;
  logic        w_periodOk, w_widthOk, w_lineGood, w_check, w_timeout;
  lock_state_t r_state, w_stateNext;
  logic [2:0]  r_goodCnt, w_goodCntNext;

  sync_edge_det u_hsync (
    .i_clk   (clk50),
    .i_rst   (reset),
    .i_async (hsync_in),
    .o_level (w_hLevel),
    .o_fall  (w_hFall),
    .o_rise  (w_hRise)
  );

  sync_edge_det u_vsync (
    .i_clk   (clk50),
    .i_rst   (reset),
    .i_async (vsync_in),
    .o_level (w_vLevel),
    .o_fall  (w_vFall),
    .o_rise  (w_vRise)
  );

  // Only the vsync falling edge matters for frame tracking.
  assign w_unusedVsync = w_vLevel ^ w_vRise;

  // Period of the line that ends on this hsync fall (hcnt was cleared on the
  // previous fall, so the fall cycle itself adds one).
  assign w_period   = {1'b0, r_hcnt} + 13'd1;
  assign w_periodOk = (w_period >= 13'(H_TOTAL - TOL)) && (w_period <= 13'(H_TOTAL + TOL));
  assign w_widthOk  = (r_hWidth >= 12'(H_SYNC - TOL)) && (r_hWidth <= 12'(H_SYNC + TOL));
  // A line whose sync pulse never went back high has no valid width.
  assign w_lineGood = w_periodOk && w_widthOk && r_widthDone;
  // The first fall after reset or loss of lock closes an unmeasured line.
  assign w_check    = w_hFall && (r_state != SEARCH);
  assign w_timeout  = (r_hcnt >= 12'(2 * H_TOTAL));

  // Horizontal position counter and line period capture.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_hcnt    <= '0;
      r_hPeriod <= '0;
    end else if (w_hFall) begin
      r_hcnt    <= '0;
      r_hPeriod <= (r_hcnt == 12'hFFF) ? 12'hFFF : w_period[11:0];
    end else if (r_hcnt != 12'hFFF) begin
      r_hcnt <= r_hcnt + 12'd1;
    end
  end

  // Sync width: the fall cycle starts at zero, each further low cycle adds
  // one, and the rise cycle adds the final one when the width is latched.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_wcnt      <= '0;
      r_hWidth    <= '0;
      r_widthDone <= 1'b0;
    end else if (w_hFall) begin
      r_wcnt      <= '0;
      r_widthDone <= 1'b0;
    end else if (w_hRise) begin
      r_hWidth    <= (r_wcnt == 12'hFFF) ? 12'hFFF : r_wcnt + 12'd1;
      r_wcnt      <= '0;
      r_widthDone <= 1'b1;
    end else if (!w_hLevel && (r_wcnt != 12'hFFF)) begin
      r_wcnt <= r_wcnt + 12'd1;
    end
  end

  // Line counter; a vsync fall takes priority over a coincident hsync fall.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_ycnt     <= '0;
      r_vLines   <= '0;
      r_newFrame <= 1'b0;
      r_lineErr  <= 1'b0;
    end else begin
      r_newFrame <= w_vFall;
      r_lineErr  <= w_check && !w_lineGood;
      if (w_vFall) begin
        r_vLines <= r_ycnt;
        r_ycnt   <= '0;
      end else if (w_hFall && (r_ycnt != 11'h7FF)) begin
        r_ycnt <= r_ycnt + 11'd1;
      end
    end
  end

  // Lock state register.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state   <= SEARCH;
      r_goodCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_goodCnt <= w_goodCntNext;
    end
  end

  // Lock next-state logic; a missing hsync for two line times drops to SEARCH.
  always_comb begin
    w_stateNext   = r_state;
    w_goodCntNext = r_goodCnt;
    case (r_state)
      SEARCH: begin
        if (w_hFall) begin
          w_stateNext   = LOCKING;
          w_goodCntNext = '0;
        end
      end
      LOCKING: begin
        if (w_hFall) begin
          if (w_lineGood) begin
            w_goodCntNext = r_goodCnt + 3'd1;
            if (r_goodCnt == 3'(LOCK_LINES - 1)) w_stateNext = LOCKED;
          end else begin
            w_goodCntNext = '0;
          end
        end else if (w_timeout) begin
          w_stateNext = SEARCH;
        end
      end
      LOCKED: begin
        if (w_hFall) begin
          if (!w_lineGood) w_stateNext = SEARCH;
        end else if (w_timeout) begin
          w_stateNext = SEARCH;
        end
      end
      default: w_stateNext = SEARCH;
    endcase
  end

  assign locked    = (r_state == LOCKED);
  assign x_pos     = r_hcnt[11] ? 11'h7FF : r_hcnt[10:0];
  assign y_pos     = r_ycnt;
  assign h_period  = r_hPeriod;
  assign h_width   = r_hWidth;
  assign v_lines   = r_vLines;
  assign new_frame = r_newFrame;
  assign line_err  = r_lineErr;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_decoder
// Directed bench for vga_sync_decoder. Lines are driven one at a time with a
// chosen period, sync width and optional vsync fall position; outputs are
// sampled 1 ns after each rising edge. A sync fall driven at line index 0 is
// registered by the decoder on the third edge, i.e. visible at index 2.
// ---------------------------------------------------------------------------
module tb_vga_sync_decoder;

  logic        clk50 = 1'b0;
  logic        reset;
  logic        hsync_in;
  logic        vsync_in;
  logic        locked;
  logic [10:0] x_pos;
  logic [10:0] y_pos;
  logic [11:0] h_period;
  logic [11:0] h_width;
  logic [10:0] v_lines;
  logic        new_frame;
  logic        line_err;

  int          nAssert = 0;
  int          nFail   = 0;
  int          errPulses;
  int          nfPulses;
  int          sumErr;
  logic        err2;
  logic        lock2;
  logic        nf2;
  logic [10:0] y2;

  always #10 clk50 = ~clk50;

  vga_sync_decoder dut (
    .clk50     (clk50),
    .reset     (reset),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .locked    (locked),
    .x_pos     (x_pos),
    .y_pos     (y_pos),
    .h_period  (h_period),
    .h_width   (h_width),
    .v_lines   (v_lines),
    .new_frame (new_frame),
    .line_err  (line_err)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  // One comparison: counts it, and counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one line starting with the hsync fall; vsync falls at index vAt
  // (negative for none) and stays low to the end of the line.
  task automatic applyStimulus(input int period, input int width, input int vAt);
    errPulses = 0;
    nfPulses  = 0;
    for (int i = 0; i < period; i++) begin
      hsync_in = (i < width) ? 1'b0 : 1'b1;
      vsync_in = ((vAt >= 0) && (i >= vAt)) ? 1'b0 : 1'b1;
      tick();
      if (line_err)  errPulses++;
      if (new_frame) nfPulses++;
      if (i == 2) begin
        err2  = line_err;
        lock2 = locked;
        nf2   = new_frame;
        y2    = y_pos;
      end
    end
  endtask

  // Every output must read zero while reset is asserted.
  task automatic checkResetOutputs(input string phase);
    checkOutput({phase, " locked"},    locked,    0);
    checkOutput({phase, " x_pos"},     x_pos,     0);
    checkOutput({phase, " y_pos"},     y_pos,     0);
    checkOutput({phase, " h_period"},  h_period,  0);
    checkOutput({phase, " h_width"},   h_width,   0);
    checkOutput({phase, " v_lines"},   v_lines,   0);
    checkOutput({phase, " new_frame"}, new_frame, 0);
    checkOutput({phase, " line_err"},  line_err,  0);
  endtask

  initial begin
    $display("[TB] vga_sync_decoder directed test");
    reset    = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) tick();
    checkResetOutputs("reset");
    reset = 1'b0;
    repeat (20) tick();

    // Nominal lines: lock after the fifth hsync fall; two short frames.
    sumErr = 0;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("L1 not locked", lock2, 0);
    applyStimulus(1040, 120, 500); sumErr += errPulses;
    checkOutput("L2 v_lines", v_lines, 2);
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("L4 not locked", lock2, 0);
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("L5 locked", lock2, 1);
    applyStimulus(1040, 120, 500); sumErr += errPulses;
    checkOutput("L6 new_frame count", nfPulses, 1);
    checkOutput("L6 v_lines", v_lines, 4);
    checkOutput("L6 y_pos", y_pos, 0);
    checkOutput("L6 h_period", h_period, 1040);
    checkOutput("L6 h_width", h_width, 120);
    checkOutput("L6 locked", locked, 1);
    checkOutput("nominal line_err count", sumErr, 0);

    // Long line while locked: error pulse, lock lost, relock after 5 falls.
    applyStimulus(1043, 120, -1);
    checkOutput("L7 still locked", locked, 1);
    applyStimulus(1040, 120, -1);
    checkOutput("L8 line_err", err2, 1);
    checkOutput("L8 lock dropped", lock2, 0);
    checkOutput("L8 single err pulse", errPulses, 1);
    checkOutput("L8 h_period", h_period, 1043);
    sumErr = 0;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("L12 not relocked", lock2, 0);
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("L13 relocked", lock2, 1);
    checkOutput("relock line_err count", sumErr, 0);

    // Tolerance edges.
    sumErr = 0;
    applyStimulus(1038, 118, -1); sumErr += errPulses;
    applyStimulus(1042, 122, -1); sumErr += errPulses;
    checkOutput("L15 h_period", h_period, 1038);
    checkOutput("L15 h_width", h_width, 122);
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("L16 h_period", h_period, 1042);
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("tolerance line_err count", sumErr, 0);
    checkOutput("L17 locked", locked, 1);

    // hsync held high after one pulse: timeout at hcnt = 2080.
    for (int i = 0; i < 2200; i++) begin
      hsync_in = (i < 120) ? 1'b0 : 1'b1;
      vsync_in = 1'b1;
      tick();
      if (i == 1000) checkOutput("x_pos mid line", x_pos, 998);
      if (i == 2082) checkOutput("locked before timeout", locked, 1);
      if (i == 2083) checkOutput("timeout drops lock", locked, 0);
    end
    checkOutput("x_pos saturates", x_pos, 2047);

    // Relock, with a narrow sync pulse flagged while LOCKING.
    applyStimulus(1040, 120, -1);
    checkOutput("R1 no check in SEARCH", errPulses, 0);
    applyStimulus(1040, 117, -1);
    checkOutput("R2 h_width", h_width, 117);
    applyStimulus(1040, 120, -1);
    checkOutput("R3 narrow sync err", err2, 1);
    checkOutput("R3 not locked", lock2, 0);
    applyStimulus(1040, 120, -1);
    applyStimulus(1040, 120, -1);
    applyStimulus(1040, 120, -1);
    checkOutput("R6 not locked", lock2, 0);
    applyStimulus(1040, 120, -1);
    checkOutput("R7 locked", lock2, 1);

    // Coincident hsync and vsync falls: vsync wins.
    applyStimulus(1040, 120, 0);
    checkOutput("S1 new_frame", nf2, 1);
    checkOutput("S1 y_pos", y2, 0);
    checkOutput("S1 v_lines", v_lines, 19);
    checkOutput("S1 still locked", lock2, 1);
    applyStimulus(1040, 120, -1);
    checkOutput("S2 y_pos", y2, 1);

    // Asynchronous reset in the middle of a locked line.
    for (int i = 0; i < 503; i++) begin
      hsync_in = (i < 120) ? 1'b0 : 1'b1;
      vsync_in = 1'b1;
      tick();
    end
    checkOutput("pre-reset x_pos", x_pos, 500);
    checkOutput("pre-reset locked", locked, 1);
    #5 reset = 1'b1;
    #1;
    checkResetOutputs("midline reset");
    tick();
    tick();
    reset = 1'b0;
    sumErr = 0;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("P1 not locked", lock2, 0);
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("P4 not locked", lock2, 0);
    applyStimulus(1040, 120, -1); sumErr += errPulses;
    checkOutput("P5 locked", lock2, 1);
    checkOutput("post-reset line_err count", sumErr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
